// File: rtl/pixel_arbiter.sv
// pixel_arbiter: per-slot sprite arbitration, BRAM fetch and pixel issue.
// Optional transparent key: define PIXEL_ARBITER_TRANSPARENT_KEY_EN.
//
// Ports:
//   clk, reset        100 MHz clock, synchronous active-high reset
//   clk25en           one-cycle pixel-slot strobe (commit point)
//   blank             1 = outside the visible area
//   request           per-sprite 1-cycle request pulses
//   address_in        packed request addresses, sprite i at [i*ADDR_W +: ADDR_W]
//   layer_in          packed layers, sprite i at [i*LAYER_W +: LAYER_W]
//   bram_en/bram_addr BRAM read port; bram_dout valid BRAM_LAT clocks later
//   pixel_out         committed pixel, held between updates
//   pixel_valid       one-cycle pulse when pixel_out updates
//   winner_id         winning sprite index (0 on blank/background)
//   collision         1 if two or more sprites requested in the slot
module pixel_arbiter #(
  parameter int N_BLOBS = 4,
  parameter int ADDR_W = 16,
  parameter int LAYER_W = 2,
  parameter int PIX_W = 12,
  parameter int BRAM_LAT = 1,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
`ifdef PIXEL_ARBITER_TRANSPARENT_KEY_EN
  ,
  parameter logic [PIX_W-1:0] KEY_COLOR = PIX_W'(12'hF0F)
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk25en,
  input  logic                         blank,
  input  logic [N_BLOBS-1:0]           request,
  input  logic [N_BLOBS*ADDR_W-1:0]    address_in,
  input  logic [N_BLOBS*LAYER_W-1:0]   layer_in,
  output logic                         bram_en,
  output logic [ADDR_W-1:0]            bram_addr,
  input  logic [PIX_W-1:0]             bram_dout,
  output logic [PIX_W-1:0]             pixel_out,
  output logic                         pixel_valid,
  output logic [$clog2(N_BLOBS)-1:0]   winner_id,
  output logic                         collision
);

  localparam int ID_W = $clog2(N_BLOBS);
  localparam logic [1:0] WAIT_LAST =
    2'((BRAM_LAT > 1) ? (BRAM_LAT - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAP,
    S_OUT
  } state_t;

  // Per-cycle winner among this cycle's request bits
  logic               cyc_hit;
  logic [LAYER_W-1:0] cyc_layer;
  logic [ADDR_W-1:0]  cyc_addr;
  logic [ID_W-1:0]    cyc_id;
  logic [1:0]         cyc_cnt;

  always_comb begin
    cyc_hit   = 1'b0;
    cyc_layer = '0;
    cyc_addr  = '0;
    cyc_id    = '0;
    cyc_cnt   = 2'd0;
    for (int i = 0; i < N_BLOBS; i++) begin
      if (request[i]) begin
        if (cyc_cnt != 2'd2) cyc_cnt = cyc_cnt + 2'd1;
        // strict compare in ascending order: ties keep the lower index
        if (!cyc_hit || layer_in[i*LAYER_W +: LAYER_W] > cyc_layer) begin
          cyc_hit   = 1'b1;
          cyc_layer = layer_in[i*LAYER_W +: LAYER_W];
          cyc_addr  = address_in[i*ADDR_W +: ADDR_W];
          cyc_id    = ID_W'(i);
        end
      end
    end
  end

  // Slot candidate
  logic               cand_vld_q, cand_vld_d;
  logic [LAYER_W-1:0] cand_layer_q, cand_layer_d;
  logic [ADDR_W-1:0]  cand_addr_q, cand_addr_d;
  logic [ID_W-1:0]    cand_id_q, cand_id_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [2:0]         cnt_sum;

  always_comb begin
    cand_vld_d   = cand_vld_q;
    cand_layer_d = cand_layer_q;
    cand_addr_d  = cand_addr_q;
    cand_id_d    = cand_id_q;
    cnt_sum      = {1'b0, cnt_q} + {1'b0, cyc_cnt};
    cnt_d        = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];
    if (clk25en) begin
      // commit cycle: restart with this cycle's requests only
      cand_vld_d   = cyc_hit;
      cand_layer_d = cyc_layer;
      cand_addr_d  = cyc_addr;
      cand_id_d    = cyc_id;
      cnt_d        = cyc_cnt;
    end else if (cyc_hit && (!cand_vld_q || cyc_layer > cand_layer_q)) begin
      cand_vld_d   = 1'b1;
      cand_layer_d = cyc_layer;
      cand_addr_d  = cyc_addr;
      cand_id_d    = cyc_id;
    end
  end

  // Issue FSM
  state_t            state_q, state_d;
  logic [1:0]        wait_q, wait_d;
  logic [ID_W-1:0]   iss_id_q, iss_id_d;
  logic              iss_coll_q, iss_coll_d;
  logic              bram_en_q, bram_en_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic              pvalid_q, pvalid_d;
  logic [ID_W-1:0]   winner_q, winner_d;
  logic              coll_q, coll_d;
  logic [PIX_W-1:0]  cap_pix;

`ifdef PIXEL_ARBITER_TRANSPARENT_KEY_EN
  assign cap_pix = (bram_dout == KEY_COLOR) ? BG_COLOR : bram_dout;
`else
  assign cap_pix = bram_dout;
`endif

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    iss_id_d    = iss_id_q;
    iss_coll_d  = iss_coll_q;
    bram_en_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    pixel_d     = pixel_q;
    pvalid_d    = 1'b0;
    winner_d    = winner_q;
    coll_d      = coll_q;
    unique case (state_q)
      // OUT is the pulse cycle; it may accept a commit like IDLE so a
      // BRAM_LAT=2 slot finishing on the next strobe is not dropped.
      S_IDLE, S_OUT: begin
        state_d = S_IDLE;
        if (clk25en) begin
          iss_id_d   = cand_id_q;
          iss_coll_d = (cnt_q == 2'd2);
          if (blank || !cand_vld_q) begin
            state_d  = S_OUT;
            pvalid_d = 1'b1;
            pixel_d  = blank ? '0 : BG_COLOR;
            winner_d = '0;
            coll_d   = (cnt_q == 2'd2);
          end else begin
            state_d     = S_READ;
            bram_en_d   = 1'b1;
            bram_addr_d = cand_addr_q;
          end
        end
      end
      S_READ: begin
        wait_d  = 2'd0;
        state_d = (BRAM_LAT > 1) ? S_WAIT : S_CAP;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_CAP;
        else wait_d = wait_q + 2'd1;
      end
      S_CAP: begin
        state_d  = S_OUT;
        pvalid_d = 1'b1;
        pixel_d  = cap_pix;
        winner_d = iss_id_q;
        coll_d   = iss_coll_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_vld_q   <= 1'b0;
      cand_layer_q <= '0;
      cand_addr_q  <= '0;
      cand_id_q    <= '0;
      cnt_q        <= 2'd0;
      state_q      <= S_IDLE;
      wait_q       <= 2'd0;
      iss_id_q     <= '0;
      iss_coll_q   <= 1'b0;
      bram_en_q    <= 1'b0;
      bram_addr_q  <= '0;
      pixel_q      <= '0;
      pvalid_q     <= 1'b0;
      winner_q     <= '0;
      coll_q       <= 1'b0;
    end else begin
      cand_vld_q   <= cand_vld_d;
      cand_layer_q <= cand_layer_d;
      cand_addr_q  <= cand_addr_d;
      cand_id_q    <= cand_id_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      wait_q       <= wait_d;
      iss_id_q     <= iss_id_d;
      iss_coll_q   <= iss_coll_d;
      bram_en_q    <= bram_en_d;
      bram_addr_q  <= bram_addr_d;
      pixel_q      <= pixel_d;
      pvalid_q     <= pvalid_d;
      winner_q     <= winner_d;
      coll_q       <= coll_d;
    end
  end

  assign bram_en     = bram_en_q;
  assign bram_addr   = bram_addr_q;
  assign pixel_out   = pixel_q;
  assign pixel_valid = pvalid_q;
  assign winner_id   = winner_q;
  assign collision   = coll_q;

endmodule

// File: tb/tb_pixel_arbiter.sv
// tb_pixel_arbiter: directed tests for pixel_arbiter.
// u_dut1 uses BRAM_LAT=1, u_dut2 uses BRAM_LAT=2 (back-to-back run).
module tb_pixel_arbiter;

  localparam logic [11:0] BG = 12'h123;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        clk25en;
  logic        blank;
  logic [3:0]  request;
  logic [63:0] address_in;
  logic [7:0]  layer_in;

  logic        en1, pv1, coll1;
  logic [15:0] addr1;
  logic [11:0] dout1, pix1;
  logic [1:0]  id1;

  logic        en2, pv2, coll2;
  logic [15:0] addr2;
  logic [11:0] dout2, s2, pix2;
  logic [1:0]  id2;

  pixel_arbiter #(.BRAM_LAT(1), .BG_COLOR(BG)) u_dut1 (
    .clk(clk), .reset(reset), .clk25en(clk25en), .blank(blank),
    .request(request), .address_in(address_in), .layer_in(layer_in),
    .bram_en(en1), .bram_addr(addr1), .bram_dout(dout1),
    .pixel_out(pix1), .pixel_valid(pv1), .winner_id(id1),
    .collision(coll1)
  );

  pixel_arbiter #(.BRAM_LAT(2), .BG_COLOR(BG)) u_dut2 (
    .clk(clk), .reset(reset), .clk25en(clk25en), .blank(blank),
    .request(request), .address_in(address_in), .layer_in(layer_in),
    .bram_en(en2), .bram_addr(addr2), .bram_dout(dout2),
    .pixel_out(pix2), .pixel_valid(pv2), .winner_id(id2),
    .collision(coll2)
  );

  logic [11:0] mem [0:255];

  always @(posedge clk) if (en1) dout1 <= mem[addr1[7:0]];
  always @(posedge clk) begin
    if (en2) s2 <= mem[addr2[7:0]];
    dout2 <= s2;
  end

  int checks = 0;
  int failures = 0;
  int phase = 0;

  logic        mon_en = 1'b0;
  logic [13:0] mon_q [$];
  always @(negedge clk) if (mon_en && pv2) mon_q.push_back({id2, pix2});

  task automatic tick();
    @(posedge clk);
    #1;
    request = '0;
    phase = (phase + 1) % 4;
    clk25en = (phase == 0);
  endtask

  task automatic wait_commit();
    for (int i = 0; i < 4 && !clk25en; i++) tick();
  endtask

  task automatic put(input int i, input logic [15:0] a, input logic [1:0] l);
    request[i] = 1'b1;
    address_in[i*16 +: 16] = a;
    layer_in[i*2 +: 2] = l;
  endtask

  // Called in a commit cycle; observes u_dut1 over the four following cycles.
  task automatic collect(output int en_cnt, output int en_at,
                         output logic [15:0] en_addr, output int pv_at,
                         output logic [11:0] pix, output logic [1:0] id,
                         output logic coll);
    en_cnt = 0; en_at = -1; en_addr = '0; pv_at = -1;
    pix = '0; id = '0; coll = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (en1) begin
        en_cnt++;
        if (en_at < 0) begin en_at = t; en_addr = addr1; end
      end
      if (pv1 && pv_at < 0) begin
        pv_at = t; pix = pix1; id = id1; coll = coll1;
      end
    end
  endtask

  int en_cnt, en_at, pv_at;
  logic [15:0] en_addr;
  logic [11:0] pix;
  logic [1:0]  id;
  logic        coll;

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (pix1 !== 12'h000) begin failures++; $display("FAIL rst_pix got=%h exp=000", pix1); end
    checks++; if (pv1 !== 1'b0) begin failures++; $display("FAIL rst_pv got=%b exp=0", pv1); end
    checks++; if (en1 !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", en1); end
    checks++; if (id1 !== 2'd0) begin failures++; $display("FAIL rst_id got=%0d exp=0", id1); end
    checks++; if (coll1 !== 1'b0) begin failures++; $display("FAIL rst_coll got=%b exp=0", coll1); end
    checks++; if (addr2 !== 16'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", addr2); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    wait_commit();
    tick();
    put(1, 16'h0010, 2'd1);
    for (int i = 0; i < 3; i++) tick();
    collect(en_cnt, en_at, en_addr, pv_at, pix, id, coll);
    checks++; if (en_at !== 1) begin failures++; $display("FAIL single_en_at got=%0d exp=1", en_at); end
    checks++; if (en_addr !== 16'h0010) begin failures++; $display("FAIL single_addr got=%h exp=0010", en_addr); end
    checks++; if (en_cnt !== 1) begin failures++; $display("FAIL single_en_cnt got=%0d exp=1", en_cnt); end
    checks++; if (pv_at !== 3) begin failures++; $display("FAIL single_lat got=%0d exp=3", pv_at); end
    checks++; if (pix !== 12'hABC) begin failures++; $display("FAIL single_pix got=%h exp=abc", pix); end
    checks++; if (id !== 2'd1) begin failures++; $display("FAIL single_id got=%0d exp=1", id); end
    checks++; if (coll !== 1'b0) begin failures++; $display("FAIL single_coll got=%b exp=0", coll); end
  endtask

  task automatic test_priority();
    wait_commit();
    put(0, 16'h0011, 2'd1);
    put(2, 16'h0012, 2'd3);
    for (int i = 0; i < 4; i++) tick();
    collect(en_cnt, en_at, en_addr, pv_at, pix, id, coll);
    checks++; if (en_addr !== 16'h0012) begin failures++; $display("FAIL prio_addr got=%h exp=0012", en_addr); end
    checks++; if (pix !== 12'h312) begin failures++; $display("FAIL prio_pix got=%h exp=312", pix); end
    checks++; if (id !== 2'd2) begin failures++; $display("FAIL prio_id got=%0d exp=2", id); end
    checks++; if (coll !== 1'b1) begin failures++; $display("FAIL prio_coll got=%b exp=1", coll); end
  endtask

  task automatic test_tie();
    wait_commit();
    put(1, 16'h0013, 2'd2);
    tick();
    tick();
    put(3, 16'h0014, 2'd2);
    tick();
    put(0, 16'h0015, 2'd1);
    tick();
    collect(en_cnt, en_at, en_addr, pv_at, pix, id, coll);
    checks++; if (en_addr !== 16'h0013) begin failures++; $display("FAIL tie_addr got=%h exp=0013", en_addr); end
    checks++; if (pix !== 12'h313) begin failures++; $display("FAIL tie_pix got=%h exp=313", pix); end
    checks++; if (id !== 2'd1) begin failures++; $display("FAIL tie_id got=%0d exp=1", id); end
    checks++; if (coll !== 1'b1) begin failures++; $display("FAIL tie_coll got=%b exp=1", coll); end
  endtask

  task automatic test_idle();
    wait_commit();
    for (int i = 0; i < 4; i++) tick();
    collect(en_cnt, en_at, en_addr, pv_at, pix, id, coll);
    checks++; if (en_cnt !== 0) begin failures++; $display("FAIL idle_en got=%0d exp=0", en_cnt); end
    checks++; if (pv_at !== 1) begin failures++; $display("FAIL idle_lat got=%0d exp=1", pv_at); end
    checks++; if (pix !== BG) begin failures++; $display("FAIL idle_pix got=%h exp=%h", pix, BG); end
    checks++; if (id !== 2'd0) begin failures++; $display("FAIL idle_id got=%0d exp=0", id); end
    checks++; if (coll !== 1'b0) begin failures++; $display("FAIL idle_coll got=%b exp=0", coll); end
  endtask

  task automatic test_blank();
    wait_commit();
    put(2, 16'h0016, 2'd1);
    put(3, 16'h0018, 2'd0);
    for (int i = 0; i < 4; i++) tick();
    blank = 1'b1;
    collect(en_cnt, en_at, en_addr, pv_at, pix, id, coll);
    blank = 1'b0;
    checks++; if (en_cnt !== 0) begin failures++; $display("FAIL blank_en got=%0d exp=0", en_cnt); end
    checks++; if (pv_at !== 1) begin failures++; $display("FAIL blank_lat got=%0d exp=1", pv_at); end
    checks++; if (pix !== 12'h000) begin failures++; $display("FAIL blank_pix got=%h exp=000", pix); end
    checks++; if (id !== 2'd0) begin failures++; $display("FAIL blank_id got=%0d exp=0", id); end
    checks++; if (coll !== 1'b1) begin failures++; $display("FAIL blank_coll got=%b exp=1", coll); end
  endtask

  task automatic test_key();
    logic [11:0] exp_pix;
`ifdef PIXEL_ARBITER_TRANSPARENT_KEY_EN
    exp_pix = BG;
`else
    exp_pix = 12'hF0F;
`endif
    wait_commit();
    put(3, 16'h0020, 2'd0);
    for (int i = 0; i < 4; i++) tick();
    collect(en_cnt, en_at, en_addr, pv_at, pix, id, coll);
    checks++; if (en_addr !== 16'h0020) begin failures++; $display("FAIL key_addr got=%h exp=0020", en_addr); end
    checks++; if (pix !== exp_pix) begin failures++; $display("FAIL key_pix got=%h exp=%h", pix, exp_pix); end
    checks++; if (id !== 2'd3) begin failures++; $display("FAIL key_id got=%0d exp=3", id); end
  endtask

  task automatic test_reset_mid();
    wait_commit();
    put(1, 16'h0010, 2'd1);
    for (int i = 0; i < 4; i++) tick();
    tick();
    checks++; if (en1 !== 1'b1) begin failures++; $display("FAIL rmid_pre_en got=%b exp=1", en1); end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pv1 !== 1'b0) begin failures++; $display("FAIL rmid_pv got=%b exp=0", pv1); end
      checks++; if (en1 !== 1'b0) begin failures++; $display("FAIL rmid_en got=%b exp=0", en1); end
      checks++; if (pix1 !== 12'h000) begin failures++; $display("FAIL rmid_pix got=%h exp=000", pix1); end
    end
    reset = 1'b0;
    wait_commit();
    put(2, 16'h0017, 2'd2);
    for (int i = 0; i < 4; i++) tick();
    collect(en_cnt, en_at, en_addr, pv_at, pix, id, coll);
    checks++; if (pv_at !== 3) begin failures++; $display("FAIL rmid_lat got=%0d exp=3", pv_at); end
    checks++; if (pix !== 12'h317) begin failures++; $display("FAIL rmid_pix_after got=%h exp=317", pix); end
    checks++; if (id !== 2'd2) begin failures++; $display("FAIL rmid_id got=%0d exp=2", id); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_pix;
    logic [7:0]  a;
    logic [13:0] got;
    wait_commit();
    mon_q.delete();
    for (int k = 0; k < 640; k++) begin
      a = 8'(k);
      put(k % 4, {8'h00, a}, 2'(k % 4));
      for (int j = 0; j < 4; j++) begin
        tick();
        if (k == 1 && j == 0) mon_en = 1'b1;
      end
    end
    for (int j = 0; j < 5; j++) tick();
    mon_en = 1'b0;
    checks++;
    if (mon_q.size() !== 640) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=640", mon_q.size());
    end
    for (int k = 0; k < 640 && k < mon_q.size(); k++) begin
      a = 8'(k);
      exp_pix = mem[a];
`ifdef PIXEL_ARBITER_TRANSPARENT_KEY_EN
      if (exp_pix == 12'hF0F) exp_pix = BG;
`endif
      got = mon_q[k];
      checks++;
      if (got !== {2'(k % 4), exp_pix}) begin
        failures++;
        $display("FAIL b2b_pix[%0d] got=%h exp=%h", k, got, {2'(k % 4), exp_pix});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {4'h3, 8'(i)};
    mem[8'h10] = 12'hABC;
    mem[8'h20] = 12'hF0F;
    reset = 1'b1;
    clk25en = 1'b1;
    blank = 1'b0;
    request = '0;
    address_in = '0;
    layer_in = '0;
    dout1 = '0;
    dout2 = '0;
    s2 = '0;
    test_reset();
    test_single();
    test_priority();
    test_tie();
    test_idle();
    test_blank();
    test_key();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
